hazard_stall_ctrl: RTL
======================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 3, is the register-specifier width.
REQ-002 Parameter LU_STALL_CYC, default 1, is the number of bubble cycles inserted per load-use hazard; legal range is 1..7.
REQ-003 Parameter CNT_W, default 16, is the stall performance-counter width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port mem_read_id_ex, input, 1 bit: the ID/EX instruction is a load.
REQ-007 Port write_reg_id_ex, input, REG_ADDR_W bits: ID/EX destination register.
REQ-008 Port write_reg_valid_id_ex, input, 1 bit: the ID/EX destination is real.
REQ-009 Ports rs_if_id and rt_if_id, inputs, REG_ADDR_W bits each: IF/ID source registers.
REQ-010 Ports rs_valid_if_id and rt_valid_if_id, inputs, 1 bit each: the IF/ID source is read.
REQ-011 Port mem_busy, input, 1 bit: data or instruction memory is not ready; the whole pipe freezes.
REQ-012 Port branch_taken, input, 1 bit: redirect resolved this cycle.
REQ-013 Port pc_write, output, 1 bit: PC update enable.
REQ-014 Port if_id_write, output, 1 bit: IF/ID register load enable.
REQ-015 Port control_zero, output, 1 bit: inject a bubble into ID/EX.
REQ-016 Port if_id_flush, output, 1 bit: squash the IF/ID contents.
REQ-017 Port stall_cnt, output, CNT_W bits: saturating stall-cycle count; present only under HAZ_PERF_CNT_EN.

Function
REQ-018 hz is defined as mem_read_id_ex AND write_reg_valid_id_ex AND ((write_reg_id_ex==rs_if_id AND rs_valid_if_id) OR (write_reg_id_ex==rt_if_id AND rt_valid_if_id)).
REQ-019 The FSM has two states: RUN and LU_STALL; a down-counter rem has width 3 bits.
REQ-020 Priority in every state SHALL be mem_busy > branch_taken > load-use.
REQ-021 Freeze (mem_busy=1) in any state:
- pc_write=0, if_id_write=0, control_zero=0, if_id_flush=0.
- State and rem hold.
REQ-022 Redirect (mem_busy=0, branch_taken=1) in any state:
- pc_write=1, if_id_write=1, control_zero=1, if_id_flush=1.
- Next state is RUN and rem becomes 0; an in-progress LU_STALL is aborted.
REQ-023 RUN with mem_busy=0, branch_taken=0 and hz=1:
- pc_write=0, if_id_write=0, control_zero=1, if_id_flush=0.
- If LU_STALL_CYC>1, next state is LU_STALL and rem becomes LU_STALL_CYC-1; otherwise the state stays RUN.
REQ-024 RUN with no event: pc_write=1, if_id_write=1, control_zero=0, if_id_flush=0.
REQ-025 LU_STALL with no freeze or redirect:
- Outputs are as in REQ-023 regardless of hz.
- rem decrements each cycle; when rem==1, next state is RUN.
REQ-026 All outputs SHALL be combinational from the current state, rem and the present inputs; detection-to-stall latency is 0 cycles.
REQ-027 A load-use hazard of LU_STALL_CYC=N SHALL produce exactly N stall cycles, excluding freeze cycles interleaved with it.

Reset
REQ-028 While rst_n=0, the following SHALL hold regardless of other inputs:
- State is RUN, rem=0 and stall_cnt=0.
- pc_write=1, if_id_write=1, control_zero=0, if_id_flush=0.
REQ-029 Assertion of rst_n mid-LU_STALL SHALL abandon the stall immediately and asynchronously.

Configuration
REQ-030 With HAZ_PERF_CNT_EN defined:
- stall_cnt increments by 1 on each clock in which pc_write=0, whether from freeze or load-use.
- stall_cnt saturates at 2^CNT_W-1.
REQ-031 Without HAZ_PERF_CNT_EN, the stall_cnt port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-032 LU_STALL_CYC=1: load to r3 in ID/EX, rs_if_id=3 valid -> exactly one cycle with pc_write=0 and control_zero=1, then RUN.
REQ-033 LU_STALL_CYC=3: same hazard -> 3 consecutive stall cycles; rem goes 2,1 then RUN, with hz held 0 after the first cycle.
REQ-034 Match on rt_if_id=5 while rt_valid_if_id=0, or write_reg_valid_id_ex=0 -> no stall.
REQ-035 LU_STALL_CYC=3, mem_busy=1 for 2 cycles during the 2nd stall cycle -> those cycles freeze with control_zero=0; the remaining stall cycles resume afterwards, giving 5 cycles with pc_write=0 in total.
REQ-036 branch_taken=1 in the 2nd LU_STALL cycle -> if_id_flush=1 and control_zero=1 that cycle, then RUN with pc_write=1.
REQ-037 HAZ_PERF_CNT_EN with CNT_W=2 and 5 stall cycles -> stall_cnt reads 3; rst_n low then reads 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use / freeze / redirect stall controller for a classic 5-stage pipe.
// Optional saturating stall counter port enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_id_ex,
    input  logic [REG_ADDR_W-1:0] write_reg_id_ex,
    input  logic                  write_reg_valid_id_ex,
    input  logic [REG_ADDR_W-1:0] rs_if_id,
    input  logic [REG_ADDR_W-1:0] rt_if_id,
    input  logic                  rs_valid_if_id,
    input  logic                  rt_valid_if_id,
    input  logic                  mem_busy,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  control_zero,
    output logic                  if_id_flush
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam logic [2:0] REM_INIT = 3'(LU_STALL_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic       hz;

    assign hz = mem_read_id_ex && write_reg_valid_id_ex &&
                (((write_reg_id_ex == rs_if_id) && rs_valid_if_id) ||
                 ((write_reg_id_ex == rt_if_id) && rt_valid_if_id));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs are gated by rst_n so reset forces RUN behaviour even with live inputs.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        control_zero = 1'b0;
        if_id_flush  = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (branch_taken) begin
                control_zero = 1'b1;
                if_id_flush  = 1'b1;
                state_d      = RUN;
                rem_d        = '0;
            end else if ((state_q == LU_STALL) || hz) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                control_zero = 1'b1;
                if (state_q == RUN) begin
                    if (LU_STALL_CYC > 1) begin
                        state_d = LU_STALL;
                        rem_d   = REM_INIT;
                    end
                end else if (rem_q <= 3'd1) begin
                    state_d = RUN;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - 3'd1;
                end
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!pc_write && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule
